// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmit path and its FIFO interface:
//   - state_t      : transmitter FSM state encoding
//   - FIFO_*       : bit masks for the 4-bit Fifo_Status flag vector
//   - DATA_BITS    : payload bits per frame
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [3:0] FIFO_EMPTY  = 4'd1;
  localparam logic [3:0] FIFO_FULL   = 4'd2;
  localparam logic [3:0] FIFO_AFULL  = 4'd4;
  localparam logic [3:0] FIFO_AEMPTY = 4'd8;

  localparam int DATA_BITS = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick
// Bit-period counter. Counts 0..Clks_Per_Bit-1 and wraps; restart forces the
// count back to 0 so the next cycle is the first cycle of a fresh bit period.
// Ports:
//   Clk        : clock
//   Reset      : synchronous, active-low reset
//   restart    : load 0 on the next edge
//   tick       : high on the last cycle of a bit period
//   tick_early : high when the following cycle will carry tick (lets callers
//                register an output that must coincide with tick)
module uart_baud_tick #(
  parameter int Clks_Per_Bit = 434
) (
  input  logic Clk,
  input  logic Reset,
  input  logic restart,
  output logic tick,
  output logic tick_early
);

  localparam int W = (Clks_Per_Bit > 1) ? $clog2(Clks_Per_Bit) : 1;
  localparam logic [W-1:0] LAST = W'(Clks_Per_Bit - 1);
  localparam logic [W-1:0] PRE  = W'(Clks_Per_Bit - 2);

  logic [W-1:0] count_reg;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      count_reg <= '0;
    end else if (restart || tick) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign tick       = (count_reg == LAST);
  // A restart overrides the increment, so the next cycle cannot be LAST.
  assign tick_early = !restart && (count_reg == PRE);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain
// UART transmitter that drains the TX FIFO: pops one byte whenever enabled and
// the FIFO is not empty, then sends start, 8 data bits LSB first, optional
// parity, and one stop bit.
// Ports:
//   Clk         : clock
//   Reset       : synchronous, active-low reset
//   Enable      : permits a new frame to start (never aborts one)
//   Fifo_Status : FIFO flags, only the Empty bit is used
//   Fifo_Data   : FIFO read data, valid the cycle after Fifo_Read
//   Fifo_Read   : one-cycle pop strobe
//   Tx          : serial output, idles high
//   Busy        : high from the pop to the end of the stop bit
//   Done        : one-cycle pulse on the final stop-bit cycle
// All outputs come straight from flops; each one is computed from the state
// being entered so it lines up with that state's cycles.
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int Clks_Per_Bit = 434,
  parameter bit Parity_En    = 1'b0,
  parameter bit Parity_Odd   = 1'b0
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Enable,
  input  logic [3:0] Fifo_Status,
  input  logic [7:0] Fifo_Data,
  output logic       Fifo_Read,
  output logic       Tx,
  output logic       Busy,
  output logic       Done
);

  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  state_t                 state_reg, state_next;
  logic [DATA_BITS-1:0]   shift_reg, shift_next;
  logic                   parity_reg, parity_next;
  logic [BIT_W-1:0]       bit_cnt_reg, bit_cnt_next;
  logic                   tx_reg, tx_next;
  logic                   read_reg, read_next;
  logic                   busy_reg, busy_next;
  logic                   done_reg, done_next;

  logic restart;
  logic tick;
  logic tick_early;
  logic empty;
  logic start_ok;

  uart_baud_tick #(
    .Clks_Per_Bit(Clks_Per_Bit)
  ) baud (
    .Clk       (Clk),
    .Reset     (Reset),
    .restart   (restart),
    .tick      (tick),
    .tick_early(tick_early)
  );

  // Empty is only consulted where start_ok is used (IDLE and the last STOP
  // cycle), so a flag that lags the pop by a cycle cannot cause a second pop.
  assign empty    = |(Fifo_Status & FIFO_EMPTY);
  assign start_ok = Enable && !empty;

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    parity_next  = parity_reg;
    bit_cnt_next = bit_cnt_reg;
    restart      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start_ok) state_next = POP;
      end
      POP: begin
        state_next = LOAD;
      end
      LOAD: begin
        shift_next   = Fifo_Data;
        parity_next  = (^Fifo_Data) ^ Parity_Odd;
        bit_cnt_next = '0;
        restart      = 1'b1;
        state_next   = START;
      end
      START: begin
        if (tick) state_next = DATA;
      end
      DATA: begin
        if (tick) begin
          shift_next = {1'b0, shift_reg[DATA_BITS-1:1]};
          if (bit_cnt_reg == LAST_BIT) begin
            state_next = Parity_En ? PARITY : STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        if (tick) state_next = STOP;
      end
      STOP: begin
        if (tick) state_next = start_ok ? POP : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = parity_next;
      default: tx_next = 1'b1;
    endcase
    read_next = (state_next == POP);
    busy_next = (state_next != IDLE);
    // STOP is always entered with the counter at 0, so tick_early inside
    // STOP marks the cycle before the last stop-bit cycle.
    done_next = (state_next == STOP) && tick_early;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      parity_reg  <= 1'b0;
      bit_cnt_reg <= '0;
      tx_reg      <= 1'b1;
      read_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      parity_reg  <= parity_next;
      bit_cnt_reg <= bit_cnt_next;
      tx_reg      <= tx_next;
      read_reg    <= read_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  assign Tx        = tx_reg;
  assign Fifo_Read = read_reg;
  assign Busy      = busy_reg;
  assign Done      = done_reg;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// tb_uart_tx_fifo_drain
// Three transmitters (no parity, even parity, odd parity) share the same
// control stimulus and each reads its own FIFO model. Every byte pushed is
// also queued as an expected frame; per-instance monitors decode the line
// cycle by cycle against the frame rules and pop the expectations.
module tb_uart_tx_fifo_drain;

  localparam int CPB = 4;

  typedef struct {
    logic [7:0] b;
    int         gap;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  logic Enable = 1'b0;
  logic lag_mode = 1'b0;
  logic mon_on = 1'b0;

  logic       tx_w   [3];
  logic       busy_w [3];
  logic       done_w [3];
  logic       rd_w   [3];
  logic [7:0] data_w [3];
  logic [3:0] stat_w [3];

  int checks = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
    localparam bit P_EN  = (gi != 0);
    localparam bit P_ODD = (gi == 2);
    localparam int FRAME = (10 + (P_EN ? 1 : 0)) * CPB;

    logic [7:0] fifo_q[$];
    exp_t       exp_q[$];
    int         pops = 0;
    logic       rd_s = 1'b0;
    logic       empty_now = 1'b1;
    logic       empty_lag = 1'b1;
    logic [7:0] data_r = 8'h00;

    assign data_w[gi] = data_r;
    assign stat_w[gi] = {3'b000, (lag_mode ? empty_lag : empty_now)};

    uart_tx_fifo_drain #(
      .Clks_Per_Bit(CPB),
      .Parity_En   (P_EN),
      .Parity_Odd  (P_ODD)
    ) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .Enable     (Enable),
      .Fifo_Status(stat_w[gi]),
      .Fifo_Data  (data_w[gi]),
      .Fifo_Read  (rd_w[gi]),
      .Tx         (tx_w[gi]),
      .Busy       (busy_w[gi]),
      .Done       (done_w[gi])
    );

    // FIFO model: data appears the cycle after the pop; empty is registered,
    // and in lag mode it trails by one more cycle.
    initial forever begin
      @(posedge Clk);
      if (rd_s) begin
        pops++;
        if (fifo_q.size() == 0) chk($sformatf("cfg%0d pop_nonempty", gi), 0, 1);
        else data_r <= fifo_q.pop_front();
      end
      empty_now <= (fifo_q.size() == 0);
      empty_lag <= empty_now;
    end

    initial begin
      int off;
      int idle_cnt;
      int bi;
      bit in_frame;
      bit abort_pend;
      bit rd_prev;
      logic exp_tx;
      logic [7:0] cur;
      exp_t e;
      off = 0; idle_cnt = 0; in_frame = 0; abort_pend = 0; rd_prev = 0; cur = 8'h00;
      forever begin
        @(negedge Clk);
        rd_s = rd_w[gi];
        if (mon_on) begin
          if (rd_prev) chk($sformatf("cfg%0d rd_single_cycle", gi), int'(rd_w[gi]), 0);
          if (rd_w[gi]) chk($sformatf("cfg%0d rd_while_empty", gi), int'(stat_w[gi][0]), 0);
          rd_prev = rd_w[gi];
          if (abort_pend) begin
            abort_pend = 0;
            in_frame = 0;
            idle_cnt = 0;
            chk($sformatf("cfg%0d rst_tx", gi), int'(tx_w[gi]), 1);
            chk($sformatf("cfg%0d rst_busy", gi), int'(busy_w[gi]), 0);
            chk($sformatf("cfg%0d rst_done", gi), int'(done_w[gi]), 0);
          end else begin
            if (!in_frame && tx_w[gi] == 1'b0) begin
              if (exp_q.size() == 0) begin
                chk($sformatf("cfg%0d unexpected_frame", gi), 1, 0);
              end else begin
                e = exp_q.pop_front();
                cur = e.b;
                if (e.gap >= 0) chk($sformatf("cfg%0d stop_gap", gi), idle_cnt, e.gap);
                in_frame = 1;
                off = 0;
              end
            end
            if (in_frame) begin
              bi = off / CPB;
              if (bi == 0) exp_tx = 1'b0;
              else if (bi <= 8) exp_tx = cur[bi-1];
              else if (P_EN && bi == 9) exp_tx = 1'(($countones(cur) + (P_ODD ? 1 : 0)) % 2);
              else exp_tx = 1'b1;
              chk($sformatf("cfg%0d tx_bit%0d", gi, bi), int'(tx_w[gi]), int'(exp_tx));
              chk($sformatf("cfg%0d done_timing", gi), int'(done_w[gi]), int'(off == FRAME - 1));
              chk($sformatf("cfg%0d busy_in_frame", gi), int'(busy_w[gi]), 1);
              off++;
              if (off == FRAME) begin
                in_frame = 0;
                idle_cnt = 0;
                $display("cfg%0d frame 0x%02h sent", gi, cur);
              end
            end else begin
              chk($sformatf("cfg%0d idle_done", gi), int'(done_w[gi]), 0);
              idle_cnt++;
            end
          end
          if (Reset == 1'b0) abort_pend = 1;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b, input int gap);
    exp_t e;
    e.b = b;
    e.gap = gap;
    g_cfg[0].fifo_q.push_back(b); g_cfg[0].exp_q.push_back(e);
    g_cfg[1].fifo_q.push_back(b); g_cfg[1].exp_q.push_back(e);
    g_cfg[2].fifo_q.push_back(b); g_cfg[2].exp_q.push_back(e);
    $display("push 0x%02h", b);
  endtask

  function automatic int pops_of(input int k);
    case (k)
      0:       return g_cfg[0].pops;
      1:       return g_cfg[1].pops;
      default: return g_cfg[2].pops;
    endcase
  endfunction

  function automatic bit all_idle();
    return g_cfg[0].fifo_q.size() == 0 && g_cfg[1].fifo_q.size() == 0 &&
           g_cfg[2].fifo_q.size() == 0 && g_cfg[0].exp_q.size() == 0 &&
           g_cfg[1].exp_q.size() == 0 && g_cfg[2].exp_q.size() == 0 &&
           !busy_w[0] && !busy_w[1] && !busy_w[2];
  endfunction

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!all_idle() && n < 5000);
    chk({name, " drain_timeout"}, int'(n >= 5000), 0);
    tick(2);
  endtask

  task automatic wait_fall(input string name);
    int n;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (tx_w[0] != 1'b0 && n < 2000);
    chk({name, " tx_fall_timeout"}, int'(n >= 2000), 0);
  endtask

  task automatic chk_pops(input string name, input int base[3], input int delta);
    for (int k = 0; k < 3; k++) chk($sformatf("cfg%0d %s", k, name), pops_of(k) - base[k], delta);
  endtask

  initial begin
    int base[3];
    int rd_seen;
    // Reset state
    tick(5);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("cfg%0d reset_tx", k), int'(tx_w[k]), 1);
      chk($sformatf("cfg%0d reset_busy", k), int'(busy_w[k]), 0);
      chk($sformatf("cfg%0d reset_read", k), int'(rd_w[k]), 0);
      chk($sformatf("cfg%0d reset_done", k), int'(done_w[k]), 0);
    end
    Reset = 1'b1;
    tick(1);
    mon_on = 1'b1;

    // Data waiting but disabled: no pop
    push(8'hA5, -1);
    rd_seen = 0;
    for (int c = 0; c < 100; c++) begin
      tick(1);
      for (int k = 0; k < 3; k++) rd_seen += int'(rd_w[k]);
    end
    chk("no_pop_while_disabled", rd_seen, 0);
    for (int k = 0; k < 3; k++) base[k] = pops_of(k);
    Enable = 1'b1;
    wait_drain("single_a5");
    chk_pops("single_pops", base, 1);

    // Parity pattern
    push(8'h03, -1);
    wait_drain("parity_03");

    // Back-to-back frames: stop bit stretched by POP+LOAD
    Enable = 1'b0;
    for (int k = 0; k < 3; k++) base[k] = pops_of(k);
    push(8'h55, -1);
    push(8'h0F, 2);
    tick(3);
    Enable = 1'b1;
    wait_drain("back_to_back");
    chk_pops("b2b_pops", base, 2);

    // Empty flag lagging the pop by a cycle
    lag_mode = 1'b1;
    tick(3);
    for (int k = 0; k < 3; k++) base[k] = pops_of(k);
    push(8'($urandom_range(0, 255)), -1);
    wait_drain("lagged_empty");
    chk_pops("lag_pops", base, 1);
    for (int k = 0; k < 3; k++) chk($sformatf("cfg%0d lag_idle_busy", k), int'(busy_w[k]), 0);
    lag_mode = 1'b0;
    tick(3);

    // Enable dropped mid-frame
    for (int k = 0; k < 3; k++) base[k] = pops_of(k);
    push(8'($urandom_range(0, 255)), -1);
    push(8'($urandom_range(0, 255)), -1);
    wait_fall("enable_drop");
    tick(1);
    Enable = 1'b0;
    tick(60);
    chk_pops("en_drop_pops", base, 1);
    for (int k = 0; k < 3; k++) chk($sformatf("cfg%0d en_drop_busy", k), int'(busy_w[k]), 0);
    tick(50);
    chk_pops("en_drop_hold_pops", base, 1);
    Enable = 1'b1;
    wait_drain("en_drop_resume");
    chk_pops("en_drop_total_pops", base, 2);

    // Reset pulse during data bit 3
    push(8'($urandom_range(0, 255)), -1);
    wait_fall("mid_reset");
    repeat (17) @(posedge Clk);
    #1;
    Reset = 1'b0;
    tick(1);
    Reset = 1'b1;
    tick(60);
    chk("mid_reset_no_resume", int'(all_idle()), 1);

    // Randomized traffic
    lag_mode = 1'($urandom_range(0, 1));
    tick(3);
    for (int i = 0; i < 30; i++) begin
      push(8'($urandom_range(0, 255)), -1);
      Enable = ($urandom_range(0, 3) != 0);
      tick($urandom_range(0, 60));
    end
    Enable = 1'b1;
    wait_drain("random");

    tick(5);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
